// File: rtl/switch_debounce_irq_ctrl_pkg.sv
// Shared definitions for the slide-switch debounce / interrupt controller:
// register word addresses and edge-capture mode encodings.
package switch_debounce_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RAW  = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Any encoding other than rise/fall is treated as "any edge".
    function automatic int edge_mode(input int edge_type);
        if (edge_type == EDGE_RISE || edge_type == EDGE_FALL) begin
            return edge_type;
        end
        return EDGE_ANY;
    endfunction

endpackage

// File: rtl/switch_debounce_irq_ctrl_if.sv
// Avalon-MM slave bus bundle between the interconnect and the switch controller.
interface switch_debounce_irq_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/switch_debounce_irq_ctrl_tick.sv
// Debounce core: a free-running sample tick plus per-bit sample/stable state.
// A bit's stable level only moves once two consecutive tick samples agree.
module switch_debounce_tick #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] agree;
    logic             tick;

    // Next-state: wrap the counter, and on the tick resample and accept agreeing bits.
    always_comb begin
        tick       = (tick_cnt_q == CNT_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
        agree      = ~(sync_in ^ sample_q);
        sample_d   = sample_q;
        stable_d   = stable_q;
        if (tick) begin
            sample_d = sync_in;
            stable_d = (stable_q & ~agree) | (sync_in & agree);
        end
    end

    // State registers; reset discards any partially elapsed debounce window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            sample_q   <= '0;
            stable_q   <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sample_q   <= sample_d;
            stable_q   <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/switch_debounce_irq_ctrl.sv
// Slide-switch controller: synchronise, debounce, capture edges into a
// write-one-to-clear register and raise a maskable level interrupt.
module switch_debounce_irq_ctrl
    import switch_debounce_irq_ctrl_pkg::*;
#(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    switch_debounce_irq_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]         in_port,
    output logic                     irq
);

    localparam int EDGE_MODE = edge_mode(EDGE_TYPE);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] rise, fall, ev, clr;
    logic             wr_en;

    switch_debounce_tick #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .sync_in(sync_q),
        .stable (stable)
    );

    // Synchroniser, edge selection, register writes and the registered read mux.
    always_comb begin
        meta_d       = in_port;
        sync_d       = meta_q;
        stable_dly_d = stable;
        rise         = stable & ~stable_dly_q;
        fall         = ~stable & stable_dly_q;
        case (EDGE_MODE)
            EDGE_RISE: ev = rise;
            EDGE_FALL: ev = fall;
            default:   ev = rise | fall;
        endcase
        wr_en  = bus.chipselect && !bus.write_n;
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && reg_addr_e'(bus.address) == ADDR_MASK) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && reg_addr_e'(bus.address) == ADDR_EDGE) begin
            clr = bus.writedata[WIDTH-1:0];
        end
        edge_d     = ev | (edge_q & ~clr);
        readdata_d = '0;
        case (reg_addr_e'(bus.address))
            ADDR_DATA: readdata_d = 32'(stable);
            ADDR_RAW:  readdata_d = 32'(sync_q);
            ADDR_MASK: readdata_d = 32'(mask_q);
            ADDR_EDGE: readdata_d = 32'(edge_q);
            default:   readdata_d = '0;
        endcase
    end

    // All controller state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q       <= '0;
            sync_q       <= '0;
            stable_dly_q <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            readdata_q   <= '0;
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            stable_dly_q <= stable_dly_d;
            mask_q       <= mask_d;
            edge_q       <= edge_d;
            readdata_q   <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_switch_debounce_irq_ctrl.sv
// Self-checking bench for switch_debounce_irq_ctrl (WIDTH 18, 4-cycle debounce tick).
module tb_switch_debounce_irq_ctrl;

    localparam int WIDTH = 18;
    localparam int DC    = 4;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;

    switch_debounce_irq_ctrl_if bus();

    switch_debounce_irq_ctrl #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DC),
        .EDGE_TYPE      (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual === required) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Reference model: ticks fall on every DC-th clock since reset, a level is
    // accepted when two successive tick samples agree, any change of the
    // debounced level is an event, and the bus rules update mask/edge/readdata.
    logic [WIDTH-1:0] m_meta = '0, m_sync = '0, m_sample = '0, m_stable = '0;
    logic [WIDTH-1:0] m_stable_prev = '0, m_mask = '0, m_edge = '0;
    logic [WIDTH-1:0] m_ev, m_clr, m_agree;
    logic [31:0]      m_rd = '0;
    int unsigned      m_cyc = 0;

    task automatic modelStep();
        if (reset) begin
            m_meta = '0; m_sync = '0; m_sample = '0; m_stable = '0;
            m_stable_prev = '0; m_mask = '0; m_edge = '0; m_rd = '0; m_cyc = 0;
        end else begin
            m_ev = m_stable ^ m_stable_prev;
            case (bus.address)
                2'd0:    m_rd = {14'b0, m_stable};
                2'd1:    m_rd = {14'b0, m_sync};
                2'd2:    m_rd = {14'b0, m_mask};
                default: m_rd = {14'b0, m_edge};
            endcase
            m_clr = '0;
            if (bus.chipselect && !bus.write_n) begin
                if (bus.address == 2'd2) m_mask = bus.writedata[WIDTH-1:0];
                if (bus.address == 2'd3) m_clr  = bus.writedata[WIDTH-1:0];
            end
            m_edge = m_ev | (m_edge & ~m_clr);
            m_stable_prev = m_stable;
            if ((m_cyc % DC) == DC - 1) begin
                m_agree  = ~(m_sync ^ m_sample);
                m_stable = (m_stable & ~m_agree) | (m_sync & m_agree);
                m_sample = m_sync;
            end
            m_sync = m_meta;
            m_meta = in_port;
            m_cyc++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        modelStep();
    end

    // Continuous comparison of the bus-visible outputs against the model.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            checkOutput("model_readdata", bus.readdata, m_rd);
            checkOutput("model_irq", {31'b0, irq}, {31'b0, |(m_edge & m_mask)});
        end
    end

    task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        applyStimulus(a, 1'b1, 1'b0, d);
        applyStimulus(a, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] v);
        applyStimulus(a, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        v = bus.readdata;
    endtask

    task automatic setInput(input logic [WIDTH-1:0] v);
        @(negedge clk);
        in_port = v;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] v;
        bit          found;

        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

        // Reset asserted mid debounce window with all switches high.
        #23 reset = 1'b0;
        waitCycles(10);
        in_port = 18'h3FFFF;
        waitCycles(6);
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_readdata", bus.readdata, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        waitCycles(2);
        #2 reset = 1'b0;
        #1;
        checkOutput("release_readdata", bus.readdata, 32'h0);
        checkOutput("release_irq", {31'b0, irq}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("reset_data_hold", bus.readdata, 32'h0);
        end
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (bus.readdata == 32'h0003_FFFF) found = 1'b1;
        end
        checkOutput("reset_data_settle", {31'b0, found}, 32'h1);

        // Bouncing bit 0 must never be accepted; the held level must be.
        setInput('0);
        waitCycles(14);
        writeReg(2'd3, ALL_ONES);
        bus.address = 2'd0;
        do @(negedge clk); while ((m_cyc % 2) != 0);
        in_port[0] = 1'b1;
        for (int u = 1; u < 40; u++) begin
            @(negedge clk);
            in_port[0] = ((u / 3) % 2) == 0;
            checkOutput("bounce_data0", {31'b0, bus.readdata[0]}, 32'h0);
        end
        @(negedge clk);
        in_port[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (bus.readdata[0]) found = 1'b1;
        end
        checkOutput("hold_data0", {31'b0, found}, 32'h1);

        // RAW shows the synchronised input two clocks after the pin changes.
        setInput('0);
        waitCycles(14);
        writeReg(2'd3, ALL_ONES);
        applyStimulus(2'd1, 1'b0, 1'b1, 32'h0);
        setInput(18'h00008);
        @(negedge clk); checkOutput("raw_lat1", bus.readdata, 32'h0);
        @(negedge clk); checkOutput("raw_lat2", bus.readdata, 32'h0);
        @(negedge clk); checkOutput("raw_lat3", bus.readdata, 32'h8);

        // Unmasked edge raises irq; W1C drops it the next clock.
        setInput('0);
        waitCycles(14);
        writeReg(2'd3, ALL_ONES);
        writeReg(2'd2, 32'h1);
        setInput(18'h00001);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (irq) found = 1'b1;
        end
        checkOutput("irq_raise", {31'b0, found}, 32'h1);
        readReg(2'd3, v);
        checkOutput("edge_set", v, 32'h1);
        writeReg(2'd3, 32'h1);
        checkOutput("irq_clear", {31'b0, irq}, 32'h0);
        readReg(2'd3, v);
        checkOutput("edge_cleared", v, 32'h0);

        // Masked edge is captured without irq; unmasking raises irq next clock.
        setInput('0);
        waitCycles(14);
        writeReg(2'd3, ALL_ONES);
        writeReg(2'd2, 32'h0);
        setInput(18'h00001);
        waitCycles(14);
        readReg(2'd3, v);
        checkOutput("masked_edge", v, 32'h1);
        checkOutput("masked_irq", {31'b0, irq}, 32'h0);
        writeReg(2'd2, 32'h1);
        checkOutput("irq_unmask", {31'b0, irq}, 32'h1);

        // A clear of bit 5 landing on the same clock as a new bit-5 event loses.
        writeReg(2'd2, 32'h0);
        writeReg(2'd3, ALL_ONES);
        setInput(18'h00021);
        waitCycles(14);
        readReg(2'd3, v);
        checkOutput("bit5_rise", v, 32'h20);
        setInput(18'h00001);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (m_stable[5] != m_stable_prev[5]) begin
                bus.address = 2'd3; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h20;
                found = 1'b1;
            end
        end
        applyStimulus(2'd3, 1'b0, 1'b1, 32'h0);
        checkOutput("simul_aligned", {31'b0, found}, 32'h1);
        readReg(2'd3, v);
        checkOutput("simul_edge5", v, 32'h20);

        // Register map table with a fixed debounced pattern.
        setInput(18'h2A5A5);
        waitCycles(14);
        writeReg(2'd3, ALL_ONES);
        writeReg(2'd2, 32'h0);
        vecs[0] = '{2'd0, 1'b1, ALL_ONES,     32'h0002_A5A5};
        vecs[1] = '{2'd1, 1'b1, ALL_ONES,     32'h0002_A5A5};
        vecs[2] = '{2'd2, 1'b1, ALL_ONES,     32'h0003_FFFF};
        vecs[3] = '{2'd0, 1'b0, 32'h0,        32'h0002_A5A5};
        vecs[4] = '{2'd2, 1'b1, 32'h0,        32'h0};
        vecs[5] = '{2'd2, 1'b1, 32'h1234_5678, 32'h0000_5678};
        vecs[6] = '{2'd3, 1'b0, 32'h0,        32'h0};
        vecs[7] = '{2'd3, 1'b1, ALL_ONES,     32'h0};
        vecs[8] = '{2'd2, 1'b1, 32'h1,        32'h1};
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) writeReg(vecs[i].addr, vecs[i].wdata);
            readReg(vecs[i].addr, v);
            checkOutput($sformatf("map%0d", i), v, vecs[i].exp);
        end

        // Read data follows the address by exactly one clock.
        writeReg(2'd2, ALL_ONES);
        applyStimulus(2'd0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("rdlat_data", bus.readdata, 32'h0002_A5A5);
        bus.address = 2'd2;
        #1 checkOutput("rdlat_hold", bus.readdata, 32'h0002_A5A5);
        @(negedge clk);
        checkOutput("rdlat_mask", bus.readdata, 32'h0003_FFFF);

        // Randomised traffic checked continuously against the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) in_port = in_port ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = ($urandom_range(0, 3) != 0);
            bus.address    = 2'($urandom_range(0, 3));
            bus.writedata  = $urandom;
        end

        applyStimulus(2'd0, 1'b0, 1'b1, 32'h0);
        waitCycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
